// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Shadows ID/EX, EX/MEM and MEM/WB register addresses and drives the EX operand-mux selects.
module forward_ctrl #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            ex_sel_a,
  output logic [1:0]            ex_sel_b
);

  localparam logic [1:0] SEL_RF  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic                  id_ex_valid_q,     id_ex_valid_d;
  logic [REG_ADDR_W-1:0] id_ex_rs1_q,       id_ex_rs1_d;
  logic [REG_ADDR_W-1:0] id_ex_rs2_q,       id_ex_rs2_d;
  logic [REG_ADDR_W-1:0] id_ex_rd_q,        id_ex_rd_d;
  logic                  id_ex_reg_write_q, id_ex_reg_write_d;
  logic                  id_ex_mem_read_q,  id_ex_mem_read_d;

  logic [REG_ADDR_W-1:0] ex_mem_rd_q,        ex_mem_rd_d;
  logic                  ex_mem_reg_write_q, ex_mem_reg_write_d;
  logic                  ex_mem_mem_read_q,  ex_mem_mem_read_d;

  logic [REG_ADDR_W-1:0] mem_wb_rd_q,        mem_wb_rd_d;
  logic                  mem_wb_reg_write_q, mem_wb_reg_write_d;

  logic ex_mem_fwd_a, ex_mem_fwd_b, mem_wb_fwd_a, mem_wb_fwd_b;

  // Load in EX followed by a dependent instruction in ID; a flush kills the consumer instead.
  always_comb begin
    stall = id_ex_valid_q && id_ex_mem_read_q && (id_ex_rd_q != '0) &&
            id_valid && !flush &&
            ((id_rs1 == id_ex_rd_q) || (id_rs2 == id_ex_rd_q));
  end

  // Next state of the tracking pipeline; bubbles carry all-zero fields.
  always_comb begin
    id_ex_valid_d     = 1'b0;
    id_ex_rs1_d       = '0;
    id_ex_rs2_d       = '0;
    id_ex_rd_d        = '0;
    id_ex_reg_write_d = 1'b0;
    id_ex_mem_read_d  = 1'b0;
    if (id_valid && !stall && !flush) begin
      id_ex_valid_d     = 1'b1;
      id_ex_rs1_d       = id_rs1;
      id_ex_rs2_d       = id_rs2;
      id_ex_rd_d        = id_rd;
      id_ex_reg_write_d = id_reg_write;
      id_ex_mem_read_d  = id_mem_read;
    end
    ex_mem_rd_d        = id_ex_rd_q;
    ex_mem_reg_write_d = id_ex_valid_q && id_ex_reg_write_q;
    ex_mem_mem_read_d  = id_ex_valid_q && id_ex_mem_read_q;
    mem_wb_rd_d        = ex_mem_rd_q;
    mem_wb_reg_write_d = ex_mem_reg_write_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      id_ex_valid_q      <= 1'b0;
      id_ex_rs1_q        <= '0;
      id_ex_rs2_q        <= '0;
      id_ex_rd_q         <= '0;
      id_ex_reg_write_q  <= 1'b0;
      id_ex_mem_read_q   <= 1'b0;
      ex_mem_rd_q        <= '0;
      ex_mem_reg_write_q <= 1'b0;
      ex_mem_mem_read_q  <= 1'b0;
      mem_wb_rd_q        <= '0;
      mem_wb_reg_write_q <= 1'b0;
    end else begin
      id_ex_valid_q      <= id_ex_valid_d;
      id_ex_rs1_q        <= id_ex_rs1_d;
      id_ex_rs2_q        <= id_ex_rs2_d;
      id_ex_rd_q         <= id_ex_rd_d;
      id_ex_reg_write_q  <= id_ex_reg_write_d;
      id_ex_mem_read_q   <= id_ex_mem_read_d;
      ex_mem_rd_q        <= ex_mem_rd_d;
      ex_mem_reg_write_q <= ex_mem_reg_write_d;
      ex_mem_mem_read_q  <= ex_mem_mem_read_d;
      mem_wb_rd_q        <= mem_wb_rd_d;
      mem_wb_reg_write_q <= mem_wb_reg_write_d;
    end
  end

  // Operand selects; x0 never forwards and the younger producer wins.
  always_comb begin
    ex_mem_fwd_a = ex_mem_reg_write_q && (ex_mem_rd_q != '0) && (ex_mem_rd_q == id_ex_rs1_q);
    ex_mem_fwd_b = ex_mem_reg_write_q && (ex_mem_rd_q != '0) && (ex_mem_rd_q == id_ex_rs2_q);
    mem_wb_fwd_a = mem_wb_reg_write_q && (mem_wb_rd_q != '0) && (mem_wb_rd_q == id_ex_rs1_q);
    mem_wb_fwd_b = mem_wb_reg_write_q && (mem_wb_rd_q != '0) && (mem_wb_rd_q == id_ex_rs2_q);
    ex_sel_a = SEL_RF;
    ex_sel_b = SEL_RF;
    if (ex_mem_fwd_a)      ex_sel_a = SEL_MEM;
    else if (mem_wb_fwd_a) ex_sel_a = SEL_WB;
    if (ex_mem_fwd_b)      ex_sel_b = SEL_MEM;
    else if (mem_wb_fwd_b) ex_sel_b = SEL_WB;
  end

  // The load-use bubble means a load in EX/MEM can never feed the instruction in EX.
  a_no_load_fwd: assert property (@(posedge clk) disable iff (!arst_n)
    !(ex_mem_mem_read_q && (ex_mem_fwd_a || ex_mem_fwd_b)));

endmodule

// File: tb/tb_forward_ctrl.sv
// Randomized scoreboard bench for forward_ctrl against an instruction-history reference model.
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, flush;
  logic       stall;
  logic [1:0] ex_sel_a, ex_sel_b;

  forward_ctrl #(.REG_ADDR_W(5)) dut (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr;
  } ins_t;

  typedef struct packed {
    logic       st;
    logic [1:0] a, b;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exq[$];
  ins_t pipe[$];   // pipe[0] in EX, pipe[1] one older, pipe[2] two older
  logic last_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t bubble();
    ins_t b;
    b = '0;
    return b;
  endfunction

  function automatic void model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(bubble());
  endfunction

  // Nearest older writer of rs among the instructions ahead of EX.
  function automatic logic [1:0] exp_sel(input logic [4:0] rs);
    if (rs == 0) return 2'b01;
    if (pipe[1].v && pipe[1].rw && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].v && pipe[2].rw && pipe[2].rd == rs) return 2'b11;
    return 2'b01;
  endfunction

  task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    exp_t e;
    ins_t n;
    @(negedge clk);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
    e.st = arst_n && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 && v && !fl &&
           (r1 == pipe[0].rd || r2 == pipe[0].rd);
    e.a  = exp_sel(pipe[0].rs1);
    e.b  = exp_sel(pipe[0].rs2);
    exq.push_back(e);
    last_stall = e.st;
    @(posedge clk);
    if (!arst_n) begin
      model_reset();
    end else begin
      n = bubble();
      if (v && !fl && !e.st) begin
        n.v = 1'b1; n.rs1 = r1; n.rs2 = r2; n.rd = rd; n.rw = rw; n.mr = mr;
      end
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs each cycle against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exq.size() != 0) begin
        e = exq.pop_front();
        chk("stall", 32'(stall), 32'(e.st));
        chk("sel_a", 32'(ex_sel_a), 32'(e.a));
        chk("sel_b", 32'(ex_sel_b), 32'(e.b));
      end
    end
  end

  initial begin
    logic       v, rw, mr, fl;
    logic [4:0] r1, r2, rd;
    model_reset();
    arst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; flush = 0;
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_sel_a", 32'(ex_sel_a), 32'd1);
    chk("reset_sel_b", 32'(ex_sel_b), 32'd1);
    nop();
    #2 arst_n = 1'b1;

    // back-to-back ALU dependence
    issue(1, 1, 2, 5, 1, 0, 0);
    issue(1, 5, 6, 8, 1, 0, 0);
    nop(); nop();
    // distance-2, then distance 1 and 2 together
    issue(1, 1, 2, 7, 1, 0, 0);
    issue(1, 1, 2, 9, 1, 0, 0);
    issue(1, 1, 7, 10, 1, 0, 0);
    issue(1, 1, 2, 7, 1, 0, 0);
    issue(1, 1, 2, 7, 1, 0, 0);
    issue(1, 3, 7, 11, 1, 0, 0);
    nop(); nop();
    // load-use with upstream holding the consumer
    issue(1, 1, 2, 3, 1, 1, 0);
    issue(1, 3, 8, 12, 1, 0, 0);
    issue(1, 3, 8, 12, 1, 0, 0);
    nop(); nop();
    // load then independent consumer
    issue(1, 1, 2, 3, 1, 1, 0);
    issue(1, 4, 9, 12, 1, 0, 0);
    nop(); nop();
    // x0 filter
    issue(1, 1, 2, 0, 1, 0, 0);
    issue(1, 0, 0, 6, 1, 0, 0);
    issue(1, 1, 2, 0, 1, 1, 0);
    issue(1, 0, 5, 6, 1, 0, 0);
    nop(); nop();
    // flush beats stall
    issue(1, 1, 2, 3, 1, 1, 0);
    issue(1, 3, 8, 12, 1, 0, 1);
    nop(); nop();

    // async reset mid-cycle during active forwarding
    issue(1, 1, 2, 5, 1, 0, 0);
    issue(1, 5, 6, 8, 1, 0, 0);
    #3;
    chk("pre_reset_sel_a", 32'(ex_sel_a), 32'd2);
    arst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_reset_stall", 32'(stall), 32'd0);
    chk("mid_reset_sel_a", 32'(ex_sel_a), 32'd1);
    chk("mid_reset_sel_b", 32'(ex_sel_b), 32'd1);
    issue(1, 1, 2, 5, 1, 1, 0);
    issue(1, 5, 5, 6, 1, 0, 0);
    #2 arst_n = 1'b1;
    issue(1, 1, 2, 5, 1, 0, 0);
    issue(1, 5, 5, 6, 1, 0, 0);
    nop(); nop();

    // randomized traffic over a small register range to provoke hazards
    v = 0; r1 = 0; r2 = 0; rd = 0; rw = 0; mr = 0; fl = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        v  = ($urandom_range(0, 99) < 85);
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        mr = ($urandom_range(0, 99) < 30);
        rw = mr | ($urandom_range(0, 99) < 70);
        fl = ($urandom_range(0, 99) < 10);
      end
      issue(v, r1, r2, rd, rw, mr, fl);
    end
    nop(); nop();
    repeat (2) @(negedge clk);
    #3;
    chk("queue_drained", 32'(exq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
